// File: rtl/counter_sequencer.sv
// Sequencer that drives an external up-counter through a programmable
// number of count passes from 0 up to a captured terminal value.
module counter_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] passes,
  input  logic [WIDTH-1:0] Q,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] pass_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] limit_r;
  logic [WIDTH-1:0] passes_r;
  logic [WIDTH-1:0] pass_next;
  logic             terminal;
  logic             last_pass;

  assign pass_next = pass_cnt + WIDTH'(1);
  assign terminal  = (Q == limit_r);
  // passes_r == 0 naturally means 2^WIDTH passes: pass_next wraps to 0 on the last one.
  assign last_pass = (pass_next == passes_r);

  // Counter controls depend on the live Q, pause and abort, so they are
  // decoded combinationally; they must steer the counter on this very edge.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    if (abort) begin
      cnt_clr = 1'b1;
    end else begin
      unique case (state)
        IDLE: cnt_clr = 1'b1;
        RUN: begin
          if (terminal)    cnt_clr = 1'b1;
          else if (!pause) cnt_en  = 1'b1;
        end
        HOLD: ;
        DONE: cnt_clr = 1'b1;
        default: cnt_clr = 1'b1;
      endcase
    end
  end

  // busy and done are registered alongside the state, so they reflect the
  // state currently held rather than the transition being decided.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state    <= IDLE;
      limit_r  <= '0;
      passes_r <= '0;
      pass_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here are overridden by later branch assignments (last NBA wins).
      busy <= 1'b0;
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              limit_r  <= limit;
              passes_r <= passes;
              pass_cnt <= '0;
              state    <= RUN;
              busy     <= 1'b1;
            end
          end
          RUN: begin
            if (terminal) begin
              pass_cnt <= pass_next;
              if (last_pass) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                busy <= 1'b1;
              end
            end else begin
              // A pause in the terminal cycle is only acted on one cycle later.
              if (pause) state <= HOLD;
              busy <= 1'b1;
            end
          end
          HOLD: begin
            if (!pause) state <= RUN;
            busy <= 1'b1;
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
